// File: rtl/plic_claim_agent.sv
`default_nettype none
// ============================================================================
// Module   : plic_claim_agent
// Claims, delivers and completes one hart's PLIC interrupts in hardware.
// Optional PLIC init sequencer: define PLIC_CLAIM_AGENT_INIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module plic_claim_agent #(
  parameter int HART_ID   = 0,
  parameter int N_INT_SRC = 32,
  parameter int W_ID      = $clog2(N_INT_SRC + 1),
  parameter int INIT_PRIO = 1,
  parameter int HOLDOFF   = 3
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            w_eip,
  output logic            o_req,
  input  logic            i_gnt,
  output logic [29:0]     o_offset,
  output logic            o_we,
  output logic [31:0]     o_wdata,
  output logic            o_re,
  input  logic [31:0]     i_rdata,
  output logic            o_irq_valid,
  output logic [W_ID-1:0] o_irq_id,
  input  logic            i_irq_ready,
  input  logic            i_irq_done,
  output logic            o_busy,
  output logic [15:0]     o_spurious
);

  localparam logic [29:0] C_CLAIM_OFS = 30'(32'h0020_0004 + 32'(HART_ID) * 32'h1000);
  localparam logic [29:0] C_THR_OFS   = 30'(32'h0020_0000 + 32'(HART_ID) * 32'h1000);
  localparam logic [29:0] C_EN_OFS    = 30'(32'h0000_2000 + 32'(HART_ID) * 32'h80);
  localparam int          C_EN_WORDS  = (N_INT_SRC + 32) / 32;
  localparam int          C_HW        = $clog2(HOLDOFF + 1) + 1;
  localparam logic [C_HW-1:0] C_HOLD  = C_HW'(HOLDOFF);

  typedef enum logic [3:0] {
`ifdef PLIC_CLAIM_AGENT_INIT_EN
    S_INIT      = 4'd0,
`endif
    S_IDLE      = 4'd1,
    S_CLAIM_REQ = 4'd2,
    S_CLAIM_RD  = 4'd3,
    S_DELIVER   = 4'd4,
    S_SERVICE   = 4'd5,
    S_CMPL_REQ  = 4'd6,
    S_HOLDOFF   = 4'd7
  } state_t;

  // Init write n: priorities 1..N first, then enable words, then threshold.
  function automatic logic [29:0] init_ofs(input logic [15:0] idx);
    int n;
    n = int'(idx);
    if (n < N_INT_SRC) return 30'(4 * (n + 1));
    if (n < N_INT_SRC + C_EN_WORDS) return C_EN_OFS + 30'(4 * (n - N_INT_SRC));
    return C_THR_OFS;
  endfunction

  function automatic logic [31:0] init_data(input logic [15:0] idx);
    int n;
    int id;
    logic [31:0] d;
    n = int'(idx);
    d = '0;
    if (n < N_INT_SRC) begin
      d = 32'(INIT_PRIO);
    end else if (n < N_INT_SRC + C_EN_WORDS) begin
      for (int b = 0; b < 32; b++) begin
        id   = 32 * (n - N_INT_SRC) + b;
        d[b] = (id >= 1) && (id <= N_INT_SRC);
      end
    end
    return d;
  endfunction

  state_t            state_q;
  logic              phase_q;    // 1 = strobe cycle of a granted bus access
  logic              re_q;
  logic              we_q;
  logic [29:0]       ofs_q;
  logic [31:0]       wdata_q;
  logic              valid_q;
  logic [W_ID-1:0]   id_q;
  logic [15:0]       spur_q;
  logic [C_HW-1:0]   hold_q;
  logic              claim_ok;
`ifdef PLIC_CLAIM_AGENT_INIT_EN
  logic [15:0]       init_idx_q;
  localparam logic [15:0] C_INIT_LAST = 16'(N_INT_SRC + C_EN_WORDS);
`endif

  assign claim_ok = (i_rdata != 32'd0) && (i_rdata <= 32'(N_INT_SRC));

  always_ff @(posedge CLK) begin
    if (RST) begin
`ifdef PLIC_CLAIM_AGENT_INIT_EN
      state_q    <= S_INIT;
      init_idx_q <= '0;
`else
      state_q    <= S_IDLE;
`endif
      phase_q <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      ofs_q   <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      spur_q  <= '0;
      hold_q  <= '0;
    end else begin
      re_q <= 1'b0;
      we_q <= 1'b0;
      case (state_q)
`ifdef PLIC_CLAIM_AGENT_INIT_EN
        S_INIT: begin
          if (!phase_q) begin
            if (i_gnt) begin
              phase_q <= 1'b1;
              we_q    <= 1'b1;
              ofs_q   <= init_ofs(init_idx_q);
              wdata_q <= init_data(init_idx_q);
            end
          end else begin
            phase_q <= 1'b0;
            if (init_idx_q == C_INIT_LAST) state_q <= S_IDLE;
            else init_idx_q <= init_idx_q + 16'd1;
          end
        end
`endif
        S_IDLE: if (w_eip) state_q <= S_CLAIM_REQ;
        S_CLAIM_REQ: begin
          if (!phase_q) begin
            if (i_gnt) begin
              phase_q <= 1'b1;
              re_q    <= 1'b1;
              ofs_q   <= C_CLAIM_OFS;
            end
          end else begin
            phase_q <= 1'b0;
            state_q <= S_CLAIM_RD;
          end
        end
        S_CLAIM_RD: begin
          if (claim_ok) begin
            id_q    <= i_rdata[W_ID-1:0];
            valid_q <= 1'b1;
            state_q <= S_DELIVER;
          end else begin
            id_q    <= '0;
            if (spur_q != 16'hFFFF) spur_q <= spur_q + 16'd1;
            hold_q  <= C_HOLD;
            state_q <= S_HOLDOFF;
          end
        end
        S_DELIVER: if (i_irq_ready) begin
          valid_q <= 1'b0;
          state_q <= S_SERVICE;
        end
        S_SERVICE: if (i_irq_done) state_q <= S_CMPL_REQ;
        S_CMPL_REQ: begin
          if (!phase_q) begin
            if (i_gnt) begin
              phase_q <= 1'b1;
              we_q    <= 1'b1;
              ofs_q   <= C_CLAIM_OFS;
              wdata_q <= 32'(id_q);
            end
          end else begin
            phase_q <= 1'b0;
            hold_q  <= C_HOLD;
            state_q <= S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          if (hold_q <= C_HW'(1)) state_q <= S_IDLE;
          else hold_q <= hold_q - C_HW'(1);
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef PLIC_CLAIM_AGENT_INIT_EN
  assign o_req = (state_q == S_INIT) || (state_q == S_CLAIM_REQ) || (state_q == S_CMPL_REQ);
`else
  assign o_req = (state_q == S_CLAIM_REQ) || (state_q == S_CMPL_REQ);
`endif
  assign o_busy      = (state_q != S_IDLE);
  assign o_re        = re_q;
  assign o_we        = we_q;
  assign o_offset    = ofs_q;
  assign o_wdata     = wdata_q;
  assign o_irq_valid = valid_q;
  assign o_irq_id    = id_q;
  assign o_spurious  = spur_q;

endmodule
`default_nettype wire

// File: tb/tb_plic_claim_agent.sv
`default_nettype none
// ============================================================================
// Module   : tb_plic_claim_agent
// Randomized transaction-level bench for plic_claim_agent (HART_ID = 1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_plic_claim_agent;

  localparam int          HART  = 1;
  localparam int          NSRC  = 32;
  localparam int          WID   = 6;
  localparam int          HOLD  = 3;
  localparam logic [31:0] CLAIM = 32'h0020_0000 + 32'h4 + 32'h1000 * HART;

  logic            clk = 1'b0;
  logic            rst;
  logic            eip;
  logic            req;
  logic            gnt;
  logic [29:0]     ofs;
  logic            we;
  logic [31:0]     wdata;
  logic            re;
  logic [31:0]     rdata;
  logic            irq_valid;
  logic [WID-1:0]  irq_id;
  logic            irq_ready;
  logic            irq_done;
  logic            busy;
  logic [15:0]     spurious;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          we_seen  = 0;
  int          re_seen  = 0;
  int          exp_we   = 0;
  int          exp_re   = 0;
  logic [15:0] exp_spur = '0;

  always #5 clk = ~clk;

  plic_claim_agent #(
    .HART_ID(HART), .N_INT_SRC(NSRC), .W_ID(WID), .INIT_PRIO(1), .HOLDOFF(HOLD)
  ) dut (
    .CLK(clk), .RST(rst), .w_eip(eip), .o_req(req), .i_gnt(gnt),
    .o_offset(ofs), .o_we(we), .o_wdata(wdata), .o_re(re), .i_rdata(rdata),
    .o_irq_valid(irq_valid), .o_irq_id(irq_id), .i_irq_ready(irq_ready),
    .i_irq_done(irq_done), .o_busy(busy), .o_spurious(spurious)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (we) we_seen++;
      if (re) re_seen++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count consecutive busy cycles (first one is the current cycle).
  task automatic count_busy(input string tag, input int exp_len);
    int n;
    n = 0;
    while (busy && n < 50) begin
      n++;
      eip = 1'($urandom_range(0, 1));
      step();
    end
    eip = 1'b0;
    chk(tag, 32'(n), 32'(exp_len));
  endtask

  task automatic chk_reset_outputs(input string tag);
`ifdef PLIC_CLAIM_AGENT_INIT_EN
    chk({tag, "_ctl"}, 32'({req, we, re, irq_valid, busy}), 32'b10001);
`else
    chk({tag, "_ctl"}, 32'({req, we, re, irq_valid, busy}), 32'b00000);
`endif
    chk({tag, "_data"}, 32'(ofs) | wdata | 32'(irq_id) | 32'(spurious), 32'd0);
  endtask

`ifdef PLIC_CLAIM_AGENT_INIT_EN
  task automatic init_seq();
    logic [29:0] eo[$];
    logic [31:0] ed[$];
    logic [63:0] en_bits;
    int n;
    en_bits = '0;
    for (int i = 1; i <= NSRC; i++) begin
      eo.push_back(30'(4 * i));
      ed.push_back(32'd1);
      en_bits[i] = 1'b1;
    end
    for (int j = 0; j < (NSRC + 32) / 32; j++) begin
      eo.push_back(30'(32'h2000 + 32'h80 * HART + 4 * j));
      ed.push_back(en_bits[32*j +: 32]);
    end
    eo.push_back(30'(32'h0020_0000 + 32'h1000 * HART));
    ed.push_back(32'd0);
    gnt = 1'b1;
    foreach (eo[k]) begin
      n = 0;
      while (!we && n < 8) begin
        step();
        n++;
      end
      chk("init_we", 32'(we), 32'd1);
      chk("init_ofs", 32'(ofs), 32'(eo[k]));
      chk("init_data", wdata, ed[k]);
      exp_we++;
      step();
    end
    chk("init_done_busy", 32'(busy), 32'd0);
  endtask
`endif

  task automatic do_reset();
    rst = 1'b1;
    step();
    chk_reset_outputs("reset");
    rst = 1'b0;
    exp_spur = '0;
`ifdef PLIC_CLAIM_AGENT_INIT_EN
    init_seq();
`endif
  endtask

  // One complete claim as seen from the PLIC and handler sides.
  task automatic run_claim(input logic [31:0] rd, input int gwait, input int rwait,
                           input bit early_done, input int cwait, input bit abort);
    bit          ok;
    logic [31:0] id;
    int          m;
    ok = (rd != 0) && (rd <= NSRC);
    id = ok ? rd : 32'd0;
    chk("idle_busy", 32'(busy), 32'd0);
    eip = 1'b1;
    gnt = (gwait == 0);
    step();
    eip = 1'($urandom_range(0, 1));
    for (int k = 0; k < gwait; k++) begin
      chk("req_wait", 32'({req, re}), 32'b10);
      step();
    end
    chk("req_pre", 32'({req, re}), 32'b10);
    gnt = 1'b1;
    step();
    chk("re_strobe", 32'({req, re, we}), 32'b110);
    chk("re_ofs", 32'(ofs), CLAIM);
    exp_re++;
    rdata = $urandom;
    gnt = 1'($urandom_range(0, 1));
    step();
    chk("rd_bus_quiet", 32'({req, re}), 32'b00);
    rdata = rd;
    step();
    rdata = $urandom;
    if (!ok) begin
      if (exp_spur != 16'hFFFF) exp_spur++;
      chk("spurious_cnt", 32'(spurious), 32'(exp_spur));
      chk("spurious_novalid", 32'(irq_valid), 32'd0);
      count_busy("spurious_holdoff", HOLD);
      return;
    end
    for (int k = 0; k < rwait; k++) begin
      chk("deliver_valid", 32'(irq_valid), 32'd1);
      chk("deliver_id", 32'(irq_id), id);
      irq_ready = 1'b0;
      irq_done  = early_done && (k == rwait / 2);
      step();
    end
    irq_done = 1'b0;
    chk("deliver_valid", 32'(irq_valid), 32'd1);
    chk("deliver_id", 32'(irq_id), id);
    irq_ready = 1'b1;
    step();
    irq_ready = 1'($urandom_range(0, 1));
    chk("service_valid", 32'(irq_valid), 32'd0);
    if (abort) begin
      do_reset();
      return;
    end
    m = $urandom_range(0, 3);
    for (int k = 0; k < m; k++) begin
      chk("service_quiet", 32'({req, we}), 32'b00);
      step();
    end
    irq_done = 1'b1;
    gnt = (cwait == 0);
    step();
    irq_done = 1'b0;
    for (int k = 0; k < cwait; k++) begin
      chk("cmpl_wait", 32'({req, we}), 32'b10);
      step();
    end
    chk("cmpl_pre", 32'({req, we}), 32'b10);
    gnt = 1'b1;
    step();
    chk("cmpl_strobe", 32'({req, we, re}), 32'b110);
    chk("cmpl_ofs", 32'(ofs), CLAIM);
    chk("cmpl_wdata", wdata, id);
    exp_we++;
    irq_ready = 1'b0;
    step();
    chk("cmpl_after", 32'({req, we}), 32'b00);
    count_busy("cmpl_holdoff", HOLD);
  endtask

  function automatic logic [31:0] pick_rdata();
    int r;
    r = $urandom_range(0, 99);
    if (r < 20) return 32'd0;
    if (r < 30) return 32'($urandom_range(NSRC + 1, 63));
    return 32'($urandom_range(1, NSRC));
  endfunction

  initial begin
    rst = 1'b1; eip = 1'b0; gnt = 1'b0; rdata = '0; irq_ready = 1'b0; irq_done = 1'b0;
    repeat (3) step();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      chk("idle_quiet", 32'({req, busy, re, we}), 32'd0);
      step();
    end
    run_claim(32'd5, 0, 0, 1'b0, 0, 1'b0);
    run_claim(32'd0, 0, 0, 1'b0, 0, 1'b0);
    run_claim(32'd7, 10, 20, 1'b1, 2, 1'b0);
    run_claim(32'd40, 1, 0, 1'b0, 0, 1'b0);
    run_claim(32'd32, 0, 3, 1'b0, 0, 1'b0);
    for (int t = 0; t < 40; t++) begin
      run_claim(pick_rdata(), $urandom_range(0, 4), $urandom_range(0, 5),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
    end
    run_claim(32'd9, 0, 0, 1'b0, 0, 1'b1);
    run_claim(32'd3, 0, 0, 1'b0, 0, 1'b0);
    chk("we_count", 32'(we_seen), 32'(exp_we));
    chk("re_count", 32'(re_seen), 32'(exp_re));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
